// File: rtl/cache_ctrl_pkg.sv
// Shared state encoding and default parameters for the cache miss controller.
package cache_ctrl_pkg;

  localparam int DEF_OFFSET_W = 2;
  localparam int DEF_MEM_LAT  = 2;
  localparam int DEF_NUM_WAYS = 2;
  localparam int DEF_INDEX_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WB     = 2'd1,
    ST_FILL   = 2'd2,
    ST_FINISH = 2'd3
  } state_e;

  // The CPU is held off only while a line is being moved to or from memory.
  function automatic logic state_busy(input state_e st);
    return (st == ST_WB) || (st == ST_FILL);
  endfunction

endpackage

// File: rtl/cache_ctrl_lat_pipe.sv
// Valid-only delay line: a read accepted by memory pops out DEPTH cycles later.
module cache_ctrl_lat_pipe #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic valid_i,
  output logic valid_o
);

  logic [DEPTH-1:0] pipe_q;
  logic [DEPTH-1:0] pipe_d;

  // shift accepted reads toward the output
  always_comb begin
    pipe_d = (pipe_q << 1'b1) | DEPTH'(valid_i);
  end

  // pipe register, emptied by reset so in-flight returns are dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign valid_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/cache_ctrl.sv
// Cache miss controller: lookup, dirty-victim write-back, pipelined line fill and
// per-set LRU tracking for a 1- or 2-way cache.
module cache_ctrl
  import cache_ctrl_pkg::*;
#(
  parameter int OFFSET_W = DEF_OFFSET_W,
  parameter int MEM_LAT  = DEF_MEM_LAT,
  parameter int NUM_WAYS = DEF_NUM_WAYS,
  parameter int INDEX_W  = DEF_INDEX_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_rd,
  input  logic                req_wr,
  input  logic [INDEX_W-1:0]  index,
  input  logic [NUM_WAYS-1:0] hit,
  input  logic [NUM_WAYS-1:0] valid,
  input  logic [NUM_WAYS-1:0] dirty,
  input  logic                mem_stall,
  output logic                stall,
  output logic                done,
  output logic                cache_hit,
  output logic                err,
  output logic                cache_wr,
  output logic                comp,
  output logic                cache_sel,
  output logic [NUM_WAYS-1:0] way_en,
  output logic [OFFSET_W-1:0] cache_offset,
  output logic [OFFSET_W-1:0] mem_offset,
  output logic                mem_wr,
  output logic                mem_rd,
  output logic                mem_tag_sel
);

  localparam int               CNT_W = OFFSET_W + 1;
  localparam logic [CNT_W-1:0] WORDS = {1'b1, {OFFSET_W{1'b0}}};
  localparam logic [CNT_W-1:0] LAST  = {1'b0, {OFFSET_W{1'b1}}};
  localparam int               SETS  = 2 ** INDEX_W;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    wb_cnt_q, wb_cnt_d;
  logic [CNT_W-1:0]    rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]    wr_cnt_q, wr_cnt_d;
  logic                victim_q, victim_d;
  logic [SETS-1:0]     lru_q, lru_d;
  logic                one_req_s;
  logic                any_hit_s;
  logic                hit_way_s;
  logic                victim_s;
  logic                victim_dirty_s;
  logic [NUM_WAYS-1:0] victim_oh_s;
  logic                rd_issue_s;
  logic                rd_accept_s;
  logic                ret_s;
  logic                fill_ret_s;
  logic                lru_we_s;
  logic                lru_wd_s;

  assign one_req_s = req_rd ^ req_wr;
  assign any_hit_s = |hit;

  // Victim choice: lowest invalid way first, otherwise the set's LRU way.
  if (NUM_WAYS == 2) begin : g_two_way
    assign hit_way_s = ~hit[0];
    assign victim_s  = ~valid[0] ? 1'b0 : (~valid[1] ? 1'b1 : lru_q[index]);
  end else begin : g_one_way
    assign hit_way_s = 1'b0;
    assign victim_s  = 1'b0;
  end

  assign victim_dirty_s = valid[victim_s] & dirty[victim_s];
  assign victim_oh_s    = NUM_WAYS'(1'b1) << victim_q;
  assign rd_issue_s     = (state_q == ST_FILL) && (rd_cnt_q < WORDS);
  assign rd_accept_s    = rd_issue_s && !mem_stall;
  assign fill_ret_s     = ret_s && (state_q == ST_FILL);

  cache_ctrl_lat_pipe #(
    .DEPTH (MEM_LAT)
  ) u_lat_pipe (
    .clk     (clk),
    .rst     (rst),
    .valid_i (rd_accept_s),
    .valid_o (ret_s)
  );

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (one_req_s && !any_hit_s) begin
          state_d = victim_dirty_s ? ST_WB : ST_FILL;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WB: begin
        if (!mem_stall && (wb_cnt_q == LAST)) begin
          state_d = ST_FILL;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_FILL: begin
        if (fill_ret_s && (wr_cnt_q == LAST)) begin
          state_d = ST_FINISH;
        end else begin
          state_d = ST_FILL;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // word counters sit at zero outside their own state, so each entry starts clean
  always_comb begin
    wb_cnt_d = '0;
    rd_cnt_d = '0;
    wr_cnt_d = '0;
    if (state_q == ST_WB) begin
      wb_cnt_d = mem_stall ? wb_cnt_q : (wb_cnt_q + 1'b1);
    end else if (state_q == ST_FILL) begin
      rd_cnt_d = rd_accept_s ? (rd_cnt_q + 1'b1) : rd_cnt_q;
      wr_cnt_d = fill_ret_s ? (wr_cnt_q + 1'b1) : wr_cnt_q;
    end else begin
      wb_cnt_d = '0;
    end
  end

  // victim capture on a lookup miss, LRU write on hit or fill completion
  always_comb begin
    lru_d = lru_q;
    if (state_q == ST_IDLE && one_req_s && !any_hit_s) begin
      victim_d = victim_s;
    end else begin
      victim_d = victim_q;
    end
    if (lru_we_s) begin
      lru_d[index] = lru_wd_s;
    end else begin
      lru_d = lru_q;
    end
  end

  // datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_cnt_q <= '0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      victim_q <= 1'b0;
      lru_q    <= '0;
    end else begin
      wb_cnt_q <= wb_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
      victim_q <= victim_d;
      lru_q    <= lru_d;
    end
  end

  // CPU, bank and memory strobes decoded from the current state
  always_comb begin
    stall        = 1'b0;
    done         = 1'b0;
    cache_hit    = 1'b0;
    err          = 1'b0;
    cache_wr     = 1'b0;
    comp         = 1'b0;
    cache_sel    = 1'b0;
    way_en       = '0;
    cache_offset = '0;
    mem_offset   = '0;
    mem_wr       = 1'b0;
    mem_rd       = 1'b0;
    mem_tag_sel  = 1'b0;
    lru_we_s     = 1'b0;
    lru_wd_s     = 1'b0;
    if (rst) begin
      stall = 1'b0;
    end else begin
      stall = state_busy(state_q);
      case (state_q)
        ST_IDLE: begin
          if (req_rd && req_wr) begin
            err = 1'b1;
          end else if (one_req_s) begin
            comp     = 1'b1;
            cache_wr = req_wr;
            way_en   = '1;
            if (any_hit_s) begin
              done      = 1'b1;
              cache_hit = 1'b1;
              lru_we_s  = 1'b1;
              lru_wd_s  = ~hit_way_s;
            end else begin
              lru_we_s  = 1'b0;
            end
          end else begin
            err = 1'b0;
          end
        end
        ST_WB: begin
          mem_wr       = 1'b1;
          mem_tag_sel  = 1'b1;
          mem_offset   = wb_cnt_q[OFFSET_W-1:0];
          cache_offset = wb_cnt_q[OFFSET_W-1:0];
          way_en       = victim_oh_s;
        end
        ST_FILL: begin
          if (rd_issue_s) begin
            mem_rd     = 1'b1;
            mem_offset = rd_cnt_q[OFFSET_W-1:0];
          end else begin
            mem_rd     = 1'b0;
          end
          // returns are written even while memory stalls new reads
          if (fill_ret_s) begin
            cache_wr     = 1'b1;
            cache_sel    = 1'b1;
            way_en       = victim_oh_s;
            cache_offset = wr_cnt_q[OFFSET_W-1:0];
          end else begin
            cache_sel    = 1'b0;
          end
        end
        ST_FINISH: begin
          comp     = 1'b1;
          cache_wr = req_wr;
          way_en   = victim_oh_s;
          done     = 1'b1;
          lru_we_s = 1'b1;
          lru_wd_s = ~victim_q;
        end
        default: begin
          stall = 1'b0;
        end
      endcase
    end
  end

endmodule
